// File: rtl/mult_rr_sched.sv
// Round-robin front end sharing one pipelined signed fixed-point multiplier
// among N_REQ requesters; each result returns MULT_LATENCY cycles after its accept.
module mult_rr_sched #(
  parameter int DATA_WIDTH   = 32,
  parameter int INT_WIDTH    = 16,
  parameter int N_REQ        = 4,
  parameter int MULT_LATENCY = 3
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]       rsp_p,
  output logic                        busy
);
  localparam int IDXW = $clog2(N_REQ);

  // Keep the operand's Q format: drop FRAC LSBs (floor) and the top INT_WIDTH bits (wrap).
  function automatic logic [DATA_WIDTH-1:0] fx_mul(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    logic signed [2*DATA_WIDTH-1:0] prod;
    prod = $signed(a) * $signed(b);
    return prod[2*DATA_WIDTH-1-INT_WIDTH -: DATA_WIDTH];
  endfunction

  logic [N_REQ-1:0][DATA_WIDTH-1:0] a_arr, b_arr;
  logic [IDXW-1:0]                  ptr, gnt_idx;
  logic [N_REQ-1:0]                 gnt;
  logic                             found, accept;
  logic [DATA_WIDTH-1:0]            a_sel, b_sel, p_out;
  logic [MULT_LATENCY:1]            vld_pipe;
  logic [MULT_LATENCY:1][N_REQ-1:0] tag_pipe;

  assign a_arr = req_a;
  assign b_arr = req_b;

  // First valid requester at or after ptr, modulo N_REQ; nothing granted in reset.
  always_comb begin
    int j;
    j       = 0;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int off = 0; off < N_REQ; off++) begin
      j = int'(ptr) + off;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req_valid[j]) begin
        found   = 1'b1;
        gnt_idx = IDXW'(j);
      end
    end
    if (found && rstn) gnt[gnt_idx] = 1'b1;
  end

  assign req_ready = gnt;
  assign accept    = |gnt;
  assign a_sel     = a_arr[gnt_idx];
  assign b_sel     = b_arr[gnt_idx];

  always_ff @(posedge clk) begin
    if (!rstn)       ptr <= '0;
    else if (accept) ptr <= (gnt_idx == IDXW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
  end

  // Valid and one-hot tag travel together; the last tag stage is the response strobe.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe[1] <= accept;
      tag_pipe[1] <= gnt;
      for (int k = 2; k <= MULT_LATENCY; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        tag_pipe[k] <= tag_pipe[k-1];
      end
    end
  end

  generate
    if (MULT_LATENCY == 1) begin : g_lat1
      logic [DATA_WIDTH-1:0] p_q;
      always_ff @(posedge clk) begin
        if (!rstn)       p_q <= '0;
        else if (accept) p_q <= fx_mul(a_sel, b_sel);
      end
      assign p_out = p_q;
    end else begin : g_latn
      // Stage 1 holds operands, stage 2 the product; later stages are free for retiming.
      logic [DATA_WIDTH-1:0]                   op_a, op_b;
      logic [MULT_LATENCY:2][DATA_WIDTH-1:0]   res_pipe;
      always_ff @(posedge clk) begin
        if (!rstn) begin
          op_a     <= '0;
          op_b     <= '0;
          res_pipe <= '0;
        end else begin
          if (accept) begin
            op_a <= a_sel;
            op_b <= b_sel;
          end
          if (vld_pipe[1]) res_pipe[2] <= fx_mul(op_a, op_b);
          for (int k = 3; k <= MULT_LATENCY; k++)
            if (vld_pipe[k-1]) res_pipe[k] <= res_pipe[k-1];
        end
      end
      assign p_out = res_pipe[MULT_LATENCY];
    end
  endgenerate

  assign rsp_valid = tag_pipe[MULT_LATENCY];
  assign rsp_p     = p_out;
  assign busy      = rstn & ((|req_valid) | (|vld_pipe));

endmodule

// File: tb/tb_mult_rr_sched.sv
// Randomized bench for mult_rr_sched against a queue-based scoreboard that
// computes products with plain 64-bit arithmetic and arbitrates by modulo search.
module tb_mult_rr_sched;
  localparam int DW = 32;
  localparam int IW = 16;
  localparam int N  = 4;
  localparam int L  = 3;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_a = '0;
  logic [N*DW-1:0] req_b = '0;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_p;
  logic            busy;

  mult_rr_sched #(.DATA_WIDTH(DW), .INT_WIDTH(IW), .N_REQ(N), .MULT_LATENCY(L)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_p(rsp_p), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int tag; logic [DW-1:0] p; int due; } exp_t;
  exp_t          q[$];
  int            ptr = 0;
  logic [DW-1:0] last_p = '0;
  logic [DW-1:0] obs_p = '0;
  int            n_chk = 0;
  int            n_pass = 0;

  function automatic logic [DW-1:0] ref_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint pa;
    pa = longint'($signed(a)) * longint'($signed(b));
    return DW'(pa >>> (DW - IW));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic check_outputs(output logic resp);
    logic [N-1:0] ev;
    exp_t         e;
    ev   = '0;
    resp = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e      = q.pop_front();
      ev     = N'(1) << e.tag;
      last_p = e.p;
      resp   = 1'b1;
    end
    chk("rsp_valid", 64'(rsp_valid), 64'(ev));
    chk("rsp_p", 64'(rsp_p), 64'(last_p));
    if (rsp_valid != '0) obs_p = rsp_p;
  endtask

  task automatic step(input logic [N-1:0] v, input logic [N*DW-1:0] a,
                      input logic [N*DW-1:0] b, output logic [N-1:0] rdy);
    logic         resp;
    int           g;
    logic [N-1:0] er;
    @(negedge clk);
    check_outputs(resp);
    req_valid = v;
    req_a     = a;
    req_b     = b;
    #1;
    g = -1;
    for (int off = 0; off < N; off++) begin
      int j;
      j = (ptr + off) % N;
      if (g < 0 && v[j]) g = j;
    end
    er  = (g < 0) ? '0 : N'(1) << g;
    rdy = req_ready;
    chk("req_ready", 64'(req_ready), 64'(er));
    if (g >= 0) begin
      q.push_back('{g, ref_mul(a[g*DW +: DW], b[g*DW +: DW]), cyc + L});
      ptr = (g + 1) % N;
    end
    if (!resp) chk("busy", 64'(busy), 64'((|v) || q.size() > 0));
  endtask

  task automatic idle(input int n);
    logic [N-1:0] r;
    repeat (n) step('0, '0, '0, r);
  endtask

  task automatic rst_cycles(input int n, input logic check_prev);
    logic resp;
    @(negedge clk);
    if (check_prev) check_outputs(resp);
    rstn      = 1'b0;
    req_valid = '1;
    #1;
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    repeat (n) begin
      @(negedge clk);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_rsp_p", 64'(rsp_p), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_ready", 64'(req_ready), 64'(0));
    end
    rstn      = 1'b1;
    req_valid = '0;
    q.delete();
    ptr    = 0;
    last_p = '0;
  endtask

  task automatic mul_one(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] expv);
    logic [N*DW-1:0] fa, fb;
    logic [N-1:0]    r;
    fa = '0;
    fb = '0;
    fa[idx*DW +: DW] = a;
    fb[idx*DW +: DW] = b;
    obs_p = 'x;
    step(N'(1) << idx, fa, fb, r);
    idle(L + 1);
    chk("mul_const", 64'(obs_p), 64'(expv));
  endtask

  function automatic logic [N*DW-1:0] rand_ops();
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++)
      v[i*DW +: DW] = ($urandom_range(0, 1) != 0) ? $urandom : DW'($signed($urandom_range(0, 8'hff)) - 128) <<< 12;
    return v;
  endfunction

  initial begin
    logic [N-1:0] r;
    rst_cycles(3, 1'b0);

    // Round-robin from a fresh pointer; first grant goes to requester 0.
    for (int i = 0; i < 8; i++) begin
      step('1, rand_ops(), rand_ops(), r);
      chk("rr_order", 64'(r), 64'(N'(1) << (i % N)));
    end
    idle(L + 1);

    // Only 1 and 3 valid: alternate, wrapping the pointer past 3.
    for (int i = 0; i < 6; i++) begin
      step(4'b1010, rand_ops(), rand_ops(), r);
      chk("skip_wrap", 64'(r), 64'((i % 2) ? 4'b1000 : 4'b0010));
    end
    idle(L + 1);

    mul_one(2, 32'h0001_8000, 32'h0002_0000, 32'h0003_0000);
    mul_one(0, 32'hFFFF_0000, 32'h0000_8000, 32'hFFFF_8000);
    mul_one(1, 32'h0000_0001, 32'hFFFF_0000, 32'hFFFF_FFFF);
    mul_one(3, 32'h0100_0000, 32'h0100_0000, 32'h0000_0000);

    for (int i = 0; i < 300; i++)
      step(N'($urandom_range(0, 15)), rand_ops(), rand_ops(), r);
    idle(L + 1);
    chk("busy_idle", 64'(busy), 64'(0));

    // Reset with operations still in the pipeline.
    step(4'b0001, rand_ops(), rand_ops(), r);
    step(4'b0100, rand_ops(), rand_ops(), r);
    step(4'b1000, rand_ops(), rand_ops(), r);
    rst_cycles(1, 1'b1);
    idle(L + 2);
    chk("busy_after_rst", 64'(busy), 64'(0));

    for (int i = 0; i < 100; i++)
      step(N'($urandom_range(0, 15)), rand_ops(), rand_ops(), r);
    idle(L + 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
